// File: rtl/ahb3lite_sram_ws.sv
// AHB-Lite SRAM slave: parameterised depth/width/wait states, byte-lane writes,
// two-cycle ERROR response for illegal transfers and same-word read-after-write forwarding.
module ahb3lite_sram_ws #(
    parameter int HADDR_SIZE     = 32,
    parameter int HDATA_SIZE     = 32,
    parameter int MEM_DEPTH_LOG2 = 14,
    parameter int WAIT_STATES    = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int BYTES = HDATA_SIZE / 8;
    localparam int ALIGN = $clog2(BYTES);
    localparam int DEPTH = 2 ** MEM_DEPTH_LOG2;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    function automatic logic addr_aligned(input logic [ALIGN-1:0] lo, input logic [2:0] size);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < ALIGN; i++) begin
            ok = ok & ~((i < int'(size)) & lo[i]);
        end
        return ok;
    endfunction

    function automatic logic [BYTES-1:0] byte_en(input logic [ALIGN-1:0] lo, input logic [2:0] size);
        logic [BYTES-1:0] be;
        int               lo_i;
        int               span;
        lo_i = int'(lo);
        span = 32'sd1 << size;
        for (int b = 0; b < BYTES; b++) begin
            be[b] = (b >= lo_i) && (b < lo_i + span);
        end
        return be;
    endfunction

    logic [HDATA_SIZE-1:0]     mem [DEPTH];

    logic [2:0]                state_r;
    logic [2:0]                state_nxt_s;
    logic [2:0]                cnt_r;
    logic [2:0]                cnt_nxt_s;
    logic [MEM_DEPTH_LOG2-1:0] idx_r;
    logic [BYTES-1:0]          be_r;
    logic                      write_r;
    logic [HDATA_SIZE-1:0]     hrdata_r;
    logic                      hreadyout_r;
    logic                      hresp_r;

    logic                      accept_s;
    logic                      addr_phase_s;
    logic                      take_s;
    logic                      legal_s;
    logic [MEM_DEPTH_LOG2-1:0] haddr_idx_s;
    logic [MEM_DEPTH_LOG2-1:0] rd_idx_s;
    logic                      rd_en_s;
    logic                      wr_en_s;
    logic [HDATA_SIZE-1:0]     wr_mask_s;
    logic [HDATA_SIZE-1:0]     mem_word_s;
    logic [HDATA_SIZE-1:0]     rd_word_s;
    logic                      unused_s;

    assign HRDATA    = hrdata_r;
    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;
    assign unused_s  = ^{HADDR[HADDR_SIZE-1:ALIGN+MEM_DEPTH_LOG2], HTRANS[0]};

    // Address-phase decode: acceptance, legality and word index.
    always_comb begin
        accept_s     = HSEL & HREADY & HTRANS[1];
        addr_phase_s = (state_r == ST_IDLE) | (state_r == ST_DATA) | (state_r == ST_ERR2);
        take_s       = accept_s & addr_phase_s;
        legal_s      = (HSIZE <= 3'(ALIGN)) && addr_aligned(HADDR[ALIGN-1:0], HSIZE);
        haddr_idx_s  = HADDR[ALIGN+MEM_DEPTH_LOG2-1:ALIGN];
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (!take_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (!legal_s) begin
                    state_nxt_s = ST_ERR1;
                end else if (WAIT_STATES > 0) begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = WS_LOAD;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 3'd0) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = cnt_r - 3'd1;
                end
            end
            ST_ERR1: state_nxt_s = ST_ERR2;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Read issue, lane mask and forwarding merge; the read lands in HRDATA on entry to DATA.
    always_comb begin
        wr_mask_s = '0;
        for (int b = 0; b < BYTES; b++) begin
            wr_mask_s[8*b +: 8] = {8{be_r[b]}};
        end
        wr_en_s    = (state_r == ST_DATA) & write_r;
        rd_idx_s   = take_s ? haddr_idx_s : idx_r;
        rd_en_s    = (state_nxt_s == ST_DATA) & (take_s ? ~HWRITE : ~write_r);
        mem_word_s = mem[rd_idx_s];
        if (wr_en_s && (rd_idx_s == idx_r)) begin
            rd_word_s = (mem_word_s & ~wr_mask_s) | (HWDATA & wr_mask_s);
        end else begin
            rd_word_s = mem_word_s;
        end
    end

    // Control state, captured address phase and registered bus outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 3'd0;
            idx_r       <= '0;
            be_r        <= '0;
            write_r     <= 1'b0;
            hrdata_r    <= '0;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            hrdata_r    <= rd_en_s ? rd_word_s : '0;
            hreadyout_r <= ~((state_nxt_s == ST_WAIT) | (state_nxt_s == ST_ERR1));
            hresp_r     <= (state_nxt_s == ST_ERR1) | (state_nxt_s == ST_ERR2);
            if (take_s) begin
                idx_r   <= haddr_idx_s;
                be_r    <= byte_en(HADDR[ALIGN-1:0], HSIZE);
                write_r <= HWRITE & legal_s;
            end else begin
                idx_r   <= idx_r;
                be_r    <= be_r;
                write_r <= write_r;
            end
        end
    end

    // Storage array: contents survive reset; enabled lanes commit at the end of DATA.
    always_ff @(posedge HCLK) begin
        if (wr_en_s) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be_r[b]) begin
                    mem[idx_r][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb3lite_sram_ws.sv
// Bench for ahb3lite_sram_ws: a zero-wait and a three-wait instance share one bus;
// a per-cycle expectation queue built from transfer-level rules checks the selected one.
module tb_ahb3lite_sram_ws;
    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        sel;
    logic [31:0] rdata0, rdata1, cur_rdata;
    logic        rdy0, rdy1, resp0, resp1, cur_rdy, cur_resp;

    always #5 HCLK = ~HCLK;

    ahb3lite_sram_ws #(.WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL & ~sel), .HADDR(HADDR), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(rdy0),
        .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0));

    ahb3lite_sram_ws #(.WAIT_STATES(3)) dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL & sel), .HADDR(HADDR), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(rdy1),
        .HRDATA(rdata1), .HREADYOUT(rdy1), .HRESP(resp1));

    assign cur_rdata = sel ? rdata1 : rdata0;
    assign cur_rdy   = sel ? rdy1 : rdy0;
    assign cur_resp  = sel ? resp1 : resp0;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] data;
        logic [1:0]  trans;
    } txn_t;

    txn_t        tq[$];
    logic [33:0] eq[$];
    logic [33:0] ce;
    bit   [7:0]  mdl [longint];
    logic [31:0] r_data [16];
    int          r_waits [16];
    logic        r_resp [16];
    int          n_tests = 0;
    int          n_fail = 0;
    logic        chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic longint mkey(input logic [31:0] a);
        return (longint'(sel) << 32) | longint'(a & 32'h0000_FFFF);
    endfunction

    function automatic logic [31:0] mdl_word(input logic [31:0] a);
        logic [31:0] w;
        longint      k;
        for (int b = 0; b < 4; b++) begin
            k = mkey((a & ~32'h3) + 32'(b));
            w[8*b +: 8] = mdl.exists(k) ? mdl[k] : 8'h00;
        end
        return w;
    endfunction

    function automatic logic is_legal(input txn_t t);
        return (t.size <= 3'd2) && ((t.addr & ((32'd1 << t.size) - 32'd1)) == 32'd0);
    endfunction

    task automatic push_exp(input txn_t t);
        int ws;
        ws = sel ? 3 : 0;
        if (!is_legal(t)) begin
            eq.push_back({1'b0, 1'b1, 32'h0});
            eq.push_back({1'b1, 1'b1, 32'h0});
        end else begin
            for (int k = 0; k < ws; k++) eq.push_back({1'b0, 1'b0, 32'h0});
            eq.push_back({1'b1, 1'b0, t.wr ? 32'h0 : mdl_word(t.addr)});
        end
    endtask

    task automatic commit(input txn_t t);
        int lo;
        lo = int'(t.addr[1:0]);
        if (t.wr && is_legal(t)) begin
            for (int b = 0; b < (1 << t.size); b++) begin
                mdl[mkey(t.addr + 32'(b))] = t.data[8*(lo+b) +: 8];
            end
        end
    endtask

    task automatic add(input logic [31:0] a, input logic w, input logic [2:0] s,
                       input logic [31:0] d, input logic [1:0] tr);
        txn_t t;
        t.addr = a; t.wr = w; t.size = s; t.data = d; t.trans = tr;
        tq.push_back(t);
    endtask

    // Pipelined master: address of transfer i overlaps the data phase of transfer dp.
    task automatic run_seq();
        int   i, dp, waits, cyc;
        logic r;
        i = 0; dp = -1; waits = 0; cyc = 0;
        while (i < tq.size() || dp >= 0) begin
            if (i < tq.size()) begin
                HSEL = 1'b1; HADDR = tq[i].addr; HWRITE = tq[i].wr;
                HSIZE = tq[i].size; HTRANS = tq[i].trans;
            end else begin
                HSEL = 1'b0; HTRANS = 2'b00;
            end
            HWDATA = (dp >= 0 && tq[dp].wr) ? tq[dp].data : 32'h0;
            @(negedge HCLK);
            r = cur_rdy;
            if (dp >= 0) begin
                if (!r) waits++;
                else begin
                    r_data[dp] = cur_rdata; r_resp[dp] = cur_resp; r_waits[dp] = waits;
                end
            end
            @(posedge HCLK); #1;
            if (r) begin
                if (dp >= 0) commit(tq[dp]);
                if (i < tq.size()) begin
                    push_exp(tq[i]); dp = i; i++; waits = 0;
                end else begin
                    dp = -1;
                end
            end
            cyc++;
            if (cyc > 200) begin
                n_tests++; n_fail++;
                $display("FAIL run_timeout: got %0d cycles expected completion", cyc);
                break;
            end
        end
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h0;
        tq.delete();
    endtask

    // Per-cycle comparison of the selected slave against the expectation queue.
    always @(negedge HCLK) begin
        if (chk_en) begin
            ce = (eq.size() > 0) ? eq.pop_front() : {1'b1, 1'b0, 32'h0};
            chk("bus", {30'd0, cur_rdy, cur_resp, cur_rdata}, {30'd0, ce});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESETn = 1'b0; sel = 1'b0; HSEL = 1'b0; HADDR = 32'h0; HWDATA = 32'h0;
        HWRITE = 1'b0; HSIZE = 3'd2; HTRANS = 2'b00;
        repeat (2) @(posedge HCLK);
        #1;
        chk("reset_dut0", {rdy0, resp0, rdata0}, {1'b1, 1'b0, 32'h0});
        chk("reset_dut1", {rdy1, resp1, rdata1}, {1'b1, 1'b0, 32'h0});
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        chk_en = 1'b1;

        // zero wait states: word write then read
        add(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 2'b10);
        add(32'h10, 1'b0, 3'd2, 32'h0, 2'b10);
        run_seq();
        chk("ws0_read", r_data[1], 32'hDEADBEEF);
        chk("ws0_waits", r_waits[1], 0);

        // byte and halfword lanes
        add(32'h20, 1'b1, 3'd2, 32'h11223344, 2'b10);
        add(32'h22, 1'b1, 3'd0, 32'hFFAAFFFF, 2'b10);
        add(32'h20, 1'b0, 3'd2, 32'h0, 2'b10);
        add(32'h20, 1'b1, 3'd1, 32'h7777BBCC, 2'b10);
        add(32'h20, 1'b0, 3'd2, 32'h0, 2'b10);
        run_seq();
        chk("byte_lane", r_data[2], 32'h11AA3344);
        chk("half_lane", r_data[4], 32'h11AABBCC);

        // illegal transfers leave memory alone
        add(32'h21, 1'b1, 3'd1, 32'h99999999, 2'b10);
        add(32'h20, 1'b1, 3'd3, 32'h88888888, 2'b10);
        add(32'h20, 1'b0, 3'd2, 32'h0, 2'b10);
        run_seq();
        chk("err_misalign", {r_resp[0], 8'(r_waits[0])}, {1'b1, 8'd1});
        chk("err_size", {r_resp[1], 8'(r_waits[1])}, {1'b1, 8'd1});
        chk("err_mem_kept", r_data[2], 32'h11AABBCC);

        // forwarding of a byte write into the next read, then an aliased address
        add(32'h40, 1'b1, 3'd2, 32'h00000000, 2'b10);
        run_seq();
        add(32'h43, 1'b1, 3'd0, 32'h55EEEEEE, 2'b10);
        add(32'h40, 1'b0, 3'd2, 32'h0, 2'b10);
        add(32'h0001_0040, 1'b0, 3'd2, 32'h0, 2'b10);
        run_seq();
        chk("raw_forward", r_data[1], 32'h55000000);
        chk("alias_read", r_data[2], 32'h55000000);

        // three wait states
        repeat (2) @(posedge HCLK);
        #1;
        sel = 1'b1;
        add(32'h100, 1'b1, 3'd2, 32'hA5A50F0F, 2'b10);
        add(32'h100, 1'b0, 3'd2, 32'h0, 2'b10);
        run_seq();
        chk("ws3_read", r_data[1], 32'hA5A50F0F);
        chk("ws3_waits", r_waits[1], 3);
        add(32'h104, 1'b1, 3'd2, 32'h01020304, 2'b10);
        add(32'h100, 1'b0, 3'd2, 32'h0, 2'b10);
        add(32'h104, 1'b0, 3'd2, 32'h0, 2'b11);
        add(32'h21, 1'b0, 3'd1, 32'h0, 2'b10);
        run_seq();
        chk("burst0", {r_data[1], 8'(r_waits[1])}, {32'hA5A50F0F, 8'd3});
        chk("burst1", {r_data[2], 8'(r_waits[2])}, {32'h01020304, 8'd3});
        chk("ws3_err", {r_resp[3], 8'(r_waits[3])}, {1'b1, 8'd1});

        // reset in the second wait cycle of a write
        add(32'h80, 1'b1, 3'd2, 32'hCAFEF00D, 2'b10);
        run_seq();
        chk_en = 1'b0;
        HSEL = 1'b1; HADDR = 32'h80; HWRITE = 1'b1; HSIZE = 3'd2; HTRANS = 2'b10;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h12345678;
        @(posedge HCLK); #1;
        chk("mid_wait", {rdy1, resp1}, {1'b0, 1'b0});
        #2;
        HRESETn = 1'b0;
        #1;
        chk("async_reset", {rdy1, resp1, rdata1}, {1'b1, 1'b0, 32'h0});
        @(posedge HCLK); #1;
        HRESETn = 1'b1; HWDATA = 32'h0;
        eq.delete();
        @(posedge HCLK); #1;
        chk_en = 1'b1;
        add(32'h80, 1'b0, 3'd2, 32'h0, 2'b10);
        run_seq();
        chk("after_reset", r_data[0], 32'hCAFEF00D);

        repeat (2) @(posedge HCLK);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb3lite_sram_ws.md
Name: ahb3lite_sram_ws

Overview:
Next-generation AHB-Lite SRAM slave for the memory subsystem. Its depth, data width and wait states are set by parameters. It supports byte and halfword writes selected by HSIZE and a registered address/data-phase pipeline. It returns a two-cycle ERROR response for illegal transfers, and forwards data when a read immediately follows a write to the same word. It sits behind the subsystem address decoder in place of the single-cycle SRAM slave.

Parameters:
HADDR_SIZE, 32, AHB address width.
HDATA_SIZE, 32, data bus width; legal values 32 or 64; BYTES = HDATA_SIZE/8, ALIGN = log2(BYTES).
MEM_DEPTH_LOG2, 14, log2 of the word count (memory holds 2**MEM_DEPTH_LOG2 words of HDATA_SIZE bits).
WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase; range 0..7.

Ports:
HCLK  in  1  clock, rising edge.
HRESETn  in  1  asynchronous active-low reset.
HSEL  in  1  slave select from decoder.
HADDR  in  HADDR_SIZE  address.
HWDATA  in  HDATA_SIZE  write data (data phase).
HWRITE  in  1  1=write.
HSIZE  in  3  transfer size.
HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ.
HREADY  in  1  bus-wide ready (previous transfer complete).
HRDATA  out  HDATA_SIZE  read data.
HREADYOUT  out  1  slave ready.
HRESP  out  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (HRESETn low, async): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, pending write discarded. Memory contents are not cleared.
- Address phase accept: HSEL & HREADY & HTRANS[1] at a rising edge. Register addr, HSIZE, HWRITE. IDLE/BUSY or HSEL=0 → no data phase; OKAY with zero waits.
- Word index = addr[ALIGN+MEM_DEPTH_LOG2-1:ALIGN]. Upper address bits are ignored, so the memory aliases.
- Illegal transfer: HSIZE > ALIGN, or addr not aligned to 2**HSIZE bytes.
  - Data phase for an illegal transfer: ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1).
  - No memory write. HRDATA=0. WAIT_STATES is not applied.
- State machine: IDLE → (legal accept, WAIT_STATES>0) WAIT → DATA; IDLE → (legal, WAIT_STATES=0) DATA; IDLE → (illegal) ERR1 → ERR2.
  - DATA and ERR2 complete the transfer. A new accepted address phase in that same cycle re-enters WAIT/DATA/ERR1 back to back.
  - Otherwise the machine returns to IDLE.
- WAIT: a counter loads WAIT_STATES-1 and decrements; HREADYOUT=0, HRESP=0 while it runs.
- Write: byte-enable mask = ((1<<2**HSIZE)-1) << addr[ALIGN-1:0]. Only enabled lanes of HWDATA are committed, at the HCLK edge ending the DATA cycle.
- Read:
  - Memory is a synchronous-read array. The read is issued so that HRDATA is valid exactly in the DATA cycle (HREADYOUT=1).
  - The full word is returned; the master selects lanes.
  - HRDATA=0 in every other cycle.
- RAW forwarding: a read whose word index equals a write committing in the same cycle returns the merged word (new bytes in enabled lanes, old bytes elsewhere). No extra wait is inserted.
- Reset asserted mid-WAIT or mid-ERR1 aborts the transfer. The pending write is lost; outputs take reset values immediately.
- HREADY low while this slave is idle → nothing is sampled.

Test Plan:
- WAIT_STATES=0, HDATA_SIZE=32: NONSEQ write word 0xDEADBEEF to 0x10, then read 0x10 → read DATA cycle HREADYOUT=1, HRESP=0, HRDATA=0xDEADBEEF, no low-ready cycles.
- Byte lanes: write word 0x11223344 to 0x20, write byte 0xAA (HSIZE=0) to 0x22, read 0x20 → 0x11AA3344. Halfword 0xBBCC to 0x20 → 0x11AABBCC.
- WAIT_STATES=3: read → exactly 3 cycles HREADYOUT=0 then one cycle HREADYOUT=1 with valid data. Back-to-back SEQ reads → 4 cycles each, no gap.
- Errors: HSIZE=1 at 0x21, then HSIZE=3 with HDATA_SIZE=32 → for each, ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1). A follow-up read of 0x20 shows memory unchanged.
- Forwarding, WAIT_STATES=0: byte write 0x55 to 0x43 immediately followed by read of 0x40 (old word 0x00000000) → HRDATA=0x55000000.
- Reset: assert HRESETn low in the 2nd wait cycle of a write (WAIT_STATES=3) → HREADYOUT=1, HRESP=0, HRDATA=0 asynchronously. A later read shows the target word unchanged.
